regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter slice.
// Reset level, grant-source codes and the default starvation limit.
package regfile_wb_arbiter_pkg;

    localparam logic        RST_ACTIVE         = 1'b0;
    localparam int unsigned STARVE_MAX_DEFAULT = 32'd4;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LONG = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channels from the in-order pipeline and the long-latency unit.
// Sources hold addr/data stable while valid is high until ready is returned.
interface regfile_wb_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          p_valid;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic          p_ready;
    logic          l_valid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_data;
    logic          l_ready;

    modport master (
        output p_valid, p_addr, p_data, l_valid, l_addr, l_data,
        input  p_ready, l_ready
    );

    modport slave (
        input  p_valid, p_addr, p_data, l_valid, l_addr, l_data,
        output p_ready, l_ready
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for registers reserved by long-latency operations.
// Tracks reservations, clears on long-unit writeback and flags decode read hazards.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    input  logic               clr_valid,
    input  logic [AW-1:0]      clr_addr,
    input  logic               rd_en_a,
    input  logic [AW-1:0]      rd_addr_a,
    input  logic               rd_en_b,
    input  logic [AW-1:0]      rd_addr_b,
    output logic               stall,
    output logic               rsv_conflict,
    output logic [(1<<AW)-1:0] busy
);
    localparam int unsigned NREG = 32'd1 << AW;

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic            conflict_r;
    logic            rsv_hit_s;
    logic            haz_a_s;
    logic            haz_b_s;

    // Set/clear masks, reservation conflict detect and read hazard compare
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (rsv_valid && (rsv_addr != '0)) begin
            set_mask_s[rsv_addr] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        if (clr_valid) begin
            clr_mask_s[clr_addr] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
        rsv_hit_s = rsv_valid && (rsv_addr != '0) && busy_r[rsv_addr];
        haz_a_s   = rd_en_a && (rd_addr_a != '0) && busy_r[rd_addr_a];
        haz_b_s   = rd_en_b && (rd_addr_b != '0) && busy_r[rd_addr_b];
    end

    // Busy vector and conflict pulse; a set applied after the clear lets set win
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            busy_r     <= '0;
            conflict_r <= 1'b0;
        end else begin
            busy_r     <= (busy_r & ~clr_mask_s) | set_mask_s;
            conflict_r <= rsv_hit_s;
        end
    end

    assign stall        = haz_a_s || haz_b_s;
    assign rsv_conflict = conflict_r;
    assign busy         = busy_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the pipeline and the long unit,
// with a starvation limit on the long unit and a busy scoreboard for its destinations.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave wb,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    input  logic               rd_en_a,
    input  logic [AW-1:0]      rd_addr_a,
    input  logic               rd_en_b,
    input  logic [AW-1:0]      rd_addr_b,
    output logic               stall,
    output logic               rsv_conflict,
    output logic               we,
    output logic [AW-1:0]      W_Addr,
    output logic [DW-1:0]      W_Data,
    output logic [(1<<AW)-1:0] busy
);
    logic          run_s;
    logic [3:0]    starve_cnt_r;
    logic          starved_s;
    logic          l_grant_s;
    logic          p_grant_s;
    wb_src_e       src_s;
    logic [AW-1:0] g_addr_s;
    logic [DW-1:0] g_data_s;
    logic          we_r;
    logic [AW-1:0] w_addr_r;
    logic [DW-1:0] w_data_r;

    assign run_s = (rst != RST_ACTIVE);

    // Grant decision: pipeline first unless the long unit has waited STARVE_MAX cycles
    always_comb begin
        starved_s = (starve_cnt_r == 4'(STARVE_MAX));
        l_grant_s = run_s && wb.l_valid && (!wb.p_valid || starved_s);
        p_grant_s = run_s && wb.p_valid && !l_grant_s;
        if (l_grant_s) begin
            src_s = WB_SRC_LONG;
        end else begin
            src_s = WB_SRC_PIPE;
        end
        case (src_s)
            WB_SRC_LONG: begin
                g_addr_s = wb.l_addr;
                g_data_s = wb.l_data;
            end
            default: begin
                g_addr_s = wb.p_addr;
                g_data_s = wb.p_data;
            end
        endcase
    end

    assign wb.p_ready = p_grant_s;
    assign wb.l_ready = l_grant_s;

    // Consecutive lost-arbitration counter for the long unit
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            starve_cnt_r <= 4'd0;
        end else if (l_grant_s || !wb.l_valid) begin
            starve_cnt_r <= 4'd0;
        end else if (!starved_s) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Regfile write register; r0 is granted but never written
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            we_r     <= 1'b0;
            w_addr_r <= '0;
            w_data_r <= '0;
        end else if (p_grant_s || l_grant_s) begin
            we_r     <= (g_addr_s != '0);
            w_addr_r <= g_addr_s;
            w_data_r <= g_data_s;
        end else begin
            we_r     <= 1'b0;
        end
    end

    assign we     = we_r;
    assign W_Addr = w_addr_r;
    assign W_Data = w_data_r;

    regfile_scoreboard #(.AW(AW)) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .clr_valid    (l_grant_s),
        .clr_addr     (wb.l_addr),
        .rd_en_a      (rd_en_a),
        .rd_addr_a    (rd_addr_a),
        .rd_en_b      (rd_en_b),
        .rd_addr_b    (rd_addr_b),
        .stall        (stall),
        .rsv_conflict (rsv_conflict),
        .busy         (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus randomized
// requesters, checked against a rule-level reference model.
module tb_regfile_wb_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rd_en_a, rd_en_b;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        stall, rsv_conflict, we;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [31:0] busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.AW(5), .DW(32)) wb ();

    regfile_wb_arbiter #(.AW(5), .DW(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .stall(stall), .rsv_conflict(rsv_conflict),
        .we(we), .W_Addr(W_Addr), .W_Data(W_Data), .busy(busy)
    );

    typedef struct {
        bit        we;
        bit [4:0]  a;
        bit [31:0] d;
        bit [31:0] busy;
        bit        conf;
    } exp_t;

    exp_t      q[$];
    int        checks = 0;
    int        errors = 0;
    bit [31:0] busy_m = 32'd0;
    int        wait_m = 0;
    bit        exp_p, exp_l, obs_p, obs_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        wb.p_valid = 1'b0; wb.p_addr = 5'd0; wb.p_data = 32'd0;
        wb.l_valid = 1'b0; wb.l_addr = 5'd0; wb.l_data = 32'd0;
        rsv_valid = 1'b0; rsv_addr = 5'd0;
        rd_en_a = 1'b0; rd_addr_a = 5'd0; rd_en_b = 1'b0; rd_addr_b = 5'd0;
    endtask

    // One cycle of stimulus: checks combinational outputs now, queues registered results
    task automatic step(input bit pv, input bit [4:0] pa, input bit [31:0] pd,
                        input bit lv, input bit [4:0] la, input bit [31:0] ld,
                        input bit rv, input bit [4:0] ra,
                        input bit ea, input bit [4:0] aa,
                        input bit eb, input bit [4:0] ab);
        exp_t e;
        bit   st;
        @(negedge clk);
        wb.p_valid = pv; wb.p_addr = pa; wb.p_data = pd;
        wb.l_valid = lv; wb.l_addr = la; wb.l_data = ld;
        rsv_valid = rv; rsv_addr = ra;
        rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
        #1;
        exp_l = lv && (!pv || wait_m >= SM);
        exp_p = pv && !exp_l;
        st    = (ea && aa != 5'd0 && busy_m[aa]) || (eb && ab != 5'd0 && busy_m[ab]);
        obs_p = wb.p_ready;
        obs_l = wb.l_ready;
        chk("p_ready", {31'd0, obs_p}, {31'd0, exp_p});
        chk("l_ready", {31'd0, obs_l}, {31'd0, exp_l});
        chk("stall", {31'd0, stall}, {31'd0, st});
        e.we   = (exp_p && pa != 5'd0) || (exp_l && la != 5'd0);
        e.a    = exp_l ? la : pa;
        e.d    = exp_l ? ld : pd;
        e.conf = rv && ra != 5'd0 && busy_m[ra];
        if (exp_l) busy_m[la] = 1'b0;
        if (rv && ra != 5'd0) busy_m[ra] = 1'b1;
        e.busy = busy_m;
        if (exp_l || !lv) wait_m = 0;
        else if (wait_m < SM) wait_m = wait_m + 1;
        q.push_back(e);
    endtask

    // Monitor: registered outputs after each active edge against queued expectations
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("we", {31'd0, we}, {31'd0, e.we});
                if (e.we) begin
                    chk("W_Addr", {27'd0, W_Addr}, {27'd0, e.a});
                    chk("W_Data", W_Data, e.d);
                end
                chk("busy", busy, e.busy);
                chk("rsv_conflict", {31'd0, rsv_conflict}, {31'd0, e.conf});
            end
        end
    end

    initial begin
        bit        pp, lp;
        bit [4:0]  pa, la;
        bit [31:0] pd, ld;
        rst = 1'b0;
        drive_idle();
        wb.p_valid = 1'b1;
        wb.l_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_W_Addr", {27'd0, W_Addr}, 32'd0);
        chk("rst_W_Data", W_Data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_p_ready", {31'd0, wb.p_ready}, 32'd0);
        chk("rst_l_ready", {31'd0, wb.l_ready}, 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;

        // Pipeline only
        repeat (3) step(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Starvation under continuous pipeline traffic
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 5'd3, 32'h3333_0000 + 32'(i), 1'b1, 5'd10, 32'h0000_BEEF,
                 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            chk("starve_l_grant_cycle", {31'd0, obs_l}, {31'd0, (i == 4)});
            chk("starve_p_grant_cycle", {31'd0, obs_p}, {31'd0, (i != 4)});
        end

        // Reserve r8, stall on read, long write clears it
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_DEAD, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 5'd8);

        // Same-cycle reserve and clear of r9, then conflicting reserve
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0909, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Address 0 on every path
        step(1'b1, 5'd0, 32'h0000_0055, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_0077, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);

        // Asynchronous reset while busy[8] is set and we is high
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 5'd3, 32'h0000_A5A5, 1'b1, 5'd4, 32'h0000_4444, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, we}, 32'd0);
        chk("async_rst_W_Addr", {27'd0, W_Addr}, 32'd0);
        chk("async_rst_W_Data", W_Data, 32'd0);
        chk("async_rst_busy", busy, 32'd0);
        chk("async_rst_p_ready", {31'd0, wb.p_ready}, 32'd0);
        chk("async_rst_l_ready", {31'd0, wb.l_ready}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        busy_m = 32'd0;
        wait_m = 0;
        q.delete();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        chk("post_rst_conflict", {31'd0, rsv_conflict}, 32'd0);

        // Random requesters that hold their request until granted
        pp = 1'b0; lp = 1'b0; pa = 5'd0; la = 5'd0; pd = 32'd0; ld = 32'd0;
        for (int n = 0; n < 400; n++) begin
            if (!pp) begin
                pp = ($urandom_range(0, 2) != 0);
                pa = 5'($urandom_range(0, 7));
                pd = $urandom;
            end
            if (!lp) begin
                lp = ($urandom_range(0, 2) == 0);
                la = 5'($urandom_range(0, 7));
                ld = $urandom;
            end
            step(pp, pa, pd, lp, la, ld,
                 ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)));
            if (exp_p) pp = 1'b0;
            if (exp_l) lp = 1'b0;
        end

        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
